// File: rtl/rand_arbiter.sv
// rand_arbiter: hands out 32-bit words from a shared XNOR LFSR to NUM_REQ
// requesters, one grant per cycle, chosen by round-robin.
//
// After a seed is loaded the LFSR is stepped WARMUP times before any word is
// handed out, so that weak seeds do not leak directly to the consumers.
// Outside of warm-up the LFSR only advances when a word is actually granted.
// Because of that, consecutive grants carry consecutive LFSR states and no
// word repeats between seed loads.
//
// Timing: req sampled at edge t -> gnt/rnd_valid/rnd_data visible during
// cycle t+1. rnd_data is the LFSR value from before the step taken at edge t.
module rand_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter int          WARMUP       = 64,
    parameter logic [31:0] DEFAULT_SEED = 32'h00000001
) (
    input  logic               rand_clk,
    input  logic               rst,
    input  logic               seed_valid,
    input  logic [31:0]        seed,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_data,
    output logic               rnd_valid,
    output logic               ready
);

    // Pointer width. NUM_REQ is always >= 2, so PW is always >= 1.
    localparam int PW = $clog2(NUM_REQ);

    // Warm-up counter width. A WARMUP of 0 still needs a 1-bit counter so
    // that the declaration stays legal.
    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    // Counter value on the cycle of the last warm-up step.
    localparam logic [CW-1:0] WARMUP_LAST = CW'((WARMUP > 0) ? (WARMUP - 1) : 0);

    // Counter value after warm-up. The counter saturates here and does not wrap.
    localparam logic [CW-1:0] WARMUP_DONE = CW'(WARMUP);

    localparam logic [PW:0]        NUM_REQ_W   = (PW + 1)'(NUM_REQ);
    localparam logic [31:0]        LOCKUP_SEED = 32'hFFFFFFFF;
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t               state_r;
    logic [31:0]          lfsr_r;
    logic [PW-1:0]        ptr_r;
    logic [CW-1:0]        warm_cnt_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [31:0]          rnd_data_r;
    logic                 rnd_valid_r;
    logic                 ready_r;

    logic                 pick_valid_s;
    logic [PW-1:0]        pick_idx_s;
    logic [PW-1:0]        cand_s;
    logic [31:0]          lfsr_step_s;
    logic [31:0]          seed_load_s;

    // One XNOR-LFSR step.
    // The register shifts left, and the new bit0 is the XNOR of taps 31, 21, 1 and 0.
    // The all-ones state is the only state from which it cannot escape.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        lfsr_next = {cur[30:0], ~(cur[31] ^ cur[21] ^ cur[1] ^ cur[0])};
    endfunction

    // (base + off) mod NUM_REQ.
    // Both operands are already below NUM_REQ, so a single conditional
    // subtract is enough.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                               input logic [PW-1:0] off);
        logic [PW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end else begin
            sum = sum;
        end
        wrap_add = sum[PW-1:0];
    endfunction

    // Next LFSR value, and the seed value actually loaded.
    // A lock-up seed is replaced by the default seed.
    always_comb begin
        lfsr_step_s = lfsr_next(lfsr_r);
        seed_load_s = (seed == LOCKUP_SEED) ? DEFAULT_SEED : seed;
    end

    // Round-robin search.
    // The loop scans offsets from high to low, so the lowest offset from
    // ptr_r that has a set req bit is written last and wins.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s       = wrap_add(ptr_r, PW'(k));
            pick_valid_s = req[cand_s] ? 1'b1   : pick_valid_s;
            pick_idx_s   = req[cand_s] ? cand_s : pick_idx_s;
        end
    end

    // Control FSM, LFSR, round-robin pointer and registered grant outputs.
    // A seed load has priority over everything except reset.
    always_ff @(posedge rand_clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_UNSEEDED;
            lfsr_r      <= DEFAULT_SEED;
            ptr_r       <= '0;
            warm_cnt_r  <= '0;
            gnt_r       <= '0;
            rnd_data_r  <= 32'h00000000;
            rnd_valid_r <= 1'b0;
            ready_r     <= 1'b0;
        end else if (seed_valid) begin
            // The seed wins over any grant that would have happened this
            // cycle; ptr_r is deliberately left unchanged.
            lfsr_r      <= seed_load_s;
            warm_cnt_r  <= '0;
            gnt_r       <= '0;
            rnd_data_r  <= 32'h00000000;
            rnd_valid_r <= 1'b0;
            if (WARMUP == 0) begin
                state_r <= ST_RUN;
                ready_r <= 1'b1;
            end else begin
                state_r <= ST_WARMUP;
                ready_r <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_UNSEEDED: begin
                    // Wait for a seed. Requests stay pending at the requesters.
                    gnt_r       <= '0;
                    rnd_data_r  <= 32'h00000000;
                    rnd_valid_r <= 1'b0;
                    ready_r     <= 1'b0;
                end
                ST_WARMUP: begin
                    // Discard one LFSR state per cycle; the last step enters RUN.
                    lfsr_r      <= lfsr_step_s;
                    gnt_r       <= '0;
                    rnd_data_r  <= 32'h00000000;
                    rnd_valid_r <= 1'b0;
                    if (warm_cnt_r == WARMUP_LAST) begin
                        warm_cnt_r <= WARMUP_DONE;
                        state_r    <= ST_RUN;
                        ready_r    <= 1'b1;
                    end else begin
                        warm_cnt_r <= warm_cnt_r + CW'(1);
                        ready_r    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    ready_r <= 1'b1;
                    if (pick_valid_s) begin
                        gnt_r       <= ONE_HOT_LSB << pick_idx_s;
                        rnd_data_r  <= lfsr_r;
                        rnd_valid_r <= 1'b1;
                        lfsr_r      <= lfsr_step_s;
                        ptr_r       <= wrap_add(pick_idx_s, PW'(1));
                    end else begin
                        gnt_r       <= '0;
                        rnd_data_r  <= 32'h00000000;
                        rnd_valid_r <= 1'b0;
                    end
                end
                default: begin
                    // An unreachable encoding falls back to waiting for a seed.
                    state_r     <= ST_UNSEEDED;
                    gnt_r       <= '0;
                    rnd_data_r  <= 32'h00000000;
                    rnd_valid_r <= 1'b0;
                    ready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign rnd_data  = rnd_data_r;
    assign rnd_valid = rnd_valid_r;
    assign ready     = ready_r;

endmodule

// File: tb/tb_rand_arbiter.sv
// Testbench for rand_arbiter.
// Two instances run side by side: one with WARMUP=0 and one with WARMUP=64.
// A per-cycle behavioural model of the grant/seed rules predicts every
// output. Directed sequences pin the model to hand-computed values, and a
// randomized phase then follows.
module tb_rand_arbiter;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sv   = 1'b0;
    logic [31:0] seed = 32'h0;
    logic [3:0]  req0 = 4'h0;
    logic [3:0]  req1 = 4'h0;

    logic [3:0]  gnt0, gnt1;
    logic [31:0] rd0, rd1;
    logic        rv0, rv1, rdy0, rdy1;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state. Index 0 is the WARMUP=0 instance, index 1 is
    // the WARMUP=64 instance. Phase encoding: 0 = unseeded, 1 = warming, 2 = run.
    int          m_phase [2];
    logic [31:0] m_lfsr  [2];
    int          m_ptr   [2];
    int          m_cnt   [2];
    logic [3:0]  m_gnt   [2];
    logic [31:0] m_rd    [2];
    logic        m_rv    [2];

    rand_arbiter #(.NUM_REQ(4), .WARMUP(0), .DEFAULT_SEED(32'h00000001)) u_dut0 (
        .rand_clk(clk), .rst(rst), .seed_valid(sv), .seed(seed), .req(req0),
        .gnt(gnt0), .rnd_data(rd0), .rnd_valid(rv0), .ready(rdy0)
    );

    rand_arbiter #(.NUM_REQ(4), .WARMUP(64), .DEFAULT_SEED(32'h00000001)) u_dut1 (
        .rand_clk(clk), .rst(rst), .seed_valid(sv), .seed(seed), .req(req1),
        .gnt(gnt1), .rnd_data(rd1), .rnd_valid(rv1), .ready(rdy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic int warm_len(input int d);
        return (d == 0) ? 0 : 64;
    endfunction

    // Next LFSR value: shift left and append 1 when the four taps hold an
    // even number of ones.
    function automatic logic [31:0] model_next(input logic [31:0] v);
        int ones;
        ones = int'(v[31]) + int'(v[21]) + int'(v[1]) + int'(v[0]);
        return (v << 1) | (((ones % 2) == 0) ? 32'h1 : 32'h0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            m_lfsr[d]  = 32'h1;
            m_ptr[d]   = 0;
            m_cnt[d]   = 0;
            m_gnt[d]   = 4'h0;
            m_rd[d]    = 32'h0;
            m_rv[d]    = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r);
        int win;
        win = -1;
        m_gnt[d] = 4'h0;
        m_rd[d]  = 32'h0;
        m_rv[d]  = 1'b0;
        if (sv) begin
            m_lfsr[d]  = (seed == 32'hFFFFFFFF) ? 32'h1 : seed;
            m_cnt[d]   = 0;
            m_phase[d] = (warm_len(d) == 0) ? 2 : 1;
        end else if (m_phase[d] == 1) begin
            m_lfsr[d] = model_next(m_lfsr[d]);
            m_cnt[d]  = m_cnt[d] + 1;
            if (m_cnt[d] == warm_len(d)) m_phase[d] = 2;
        end else if (m_phase[d] == 2 && r != 4'h0) begin
            for (int k = 0; k < 4; k++)
                if (win < 0 && r[(m_ptr[d] + k) % 4]) win = (m_ptr[d] + k) % 4;
            m_gnt[d]  = 4'(1 << win);
            m_rd[d]   = m_lfsr[d];
            m_rv[d]   = 1'b1;
            m_lfsr[d] = model_next(m_lfsr[d]);
            m_ptr[d]  = (win + 1) % 4;
        end
    endtask

    // Advance the model on every rising clock edge, and reset it while rst is high.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                model_step(0, req0);
                model_step(1, req1);
            end
        end
    end

    // Compare both instances against the model on every falling edge outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("gnt0",   {28'h0, gnt0}, {28'h0, m_gnt[0]});
                chk("rv0",    {31'h0, rv0},  {31'h0, m_rv[0]});
                chk("rd0",    rd0,           m_rd[0]);
                chk("ready0", {31'h0, rdy0}, {31'h0, (m_phase[0] == 2)});
                chk("gnt1",   {28'h0, gnt1}, {28'h0, m_gnt[1]});
                chk("rv1",    {31'h0, rv1},  {31'h0, m_rv[1]});
                chk("rd1",    rd1,           m_rd[1]);
                chk("ready1", {31'h0, rdy1}, {31'h0, (m_phase[1] == 2)});
            end
        end
    end

    logic [31:0] exp_rd  [5];
    logic [3:0]  exp_gnt [5];
    int first_rdy, first_gnt, seen;
    logic prev_sv;

    initial begin
        exp_rd = '{32'h1, 32'h2, 32'h4, 32'h9, 32'h12};

        // Power-on reset, then check the idle outputs.
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_gnt0", {28'h0, gnt0}, 32'h0);
        chk("reset_ready1", {31'h0, rdy1}, 32'h0);
        chk("reset_rd1", rd1, 32'h0);

        // Seed 1 with one requester held on each instance.
        // The WARMUP=0 instance must deliver the known word sequence.
        // The WARMUP=64 instance must raise ready on the 64th step edge and
        // grant on the edge after that.
        @(negedge clk);
        req0 = 4'b0001; req1 = 4'b0001; sv = 1'b1; seed = 32'h1;
        @(negedge clk);
        sv = 1'b0;
        #1;
        chk("seed_ready0", {31'h0, rdy0}, 32'h1);
        first_rdy = -1; first_gnt = -1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            #1;
            if (k <= 5) begin
                chk("single_gnt", {28'h0, gnt0}, 32'h1);
                chk("single_rd", rd0, exp_rd[k-1]);
            end
            if (rdy1 && first_rdy < 0) first_rdy = k;
            if (gnt1 != 4'h0 && first_gnt < 0) first_gnt = k;
        end
        chk("warm_ready_edge", first_rdy, 32'd64);
        chk("warm_first_gnt", first_gnt, 32'd65);

        // Reset in the middle of a grant stream.
        // Outputs must clear at once, and no grant may appear until a new seed.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_gnt0", {28'h0, gnt0}, 32'h0);
        chk("async_rv0", {31'h0, rv0}, 32'h0);
        chk("async_ready0", {31'h0, rdy0}, 32'h0);
        #1 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("unseeded_gnt0", {28'h0, gnt0}, 32'h0);
        end

        // All four requesting from ptr=0: rotating grants, same word sequence.
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req0 = 4'b1111; req1 = 4'b0000; sv = 1'b1; seed = 32'h1;
        @(negedge clk);
        sv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("rr_gnt", {28'h0, gnt0}, {28'h0, exp_gnt[k]});
            chk("rr_rd", rd0, exp_rd[k]);
        end

        // A lock-up seed loads the default seed instead.
        // The cycle of the load carries no grant.
        req0 = 4'b0001; sv = 1'b1; seed = 32'hFFFFFFFF;
        @(negedge clk);
        sv = 1'b0;
        #1;
        chk("lockup_nogrant", {28'h0, gnt0}, 32'h0);
        @(negedge clk);
        #1;
        chk("lockup_rd", rd0, 32'h1);

        // A seed arriving in a grant cycle on the WARMUP=64 instance.
        // The seed wins: no grant, and the instance drops back to warm-up.
        req1 = 4'b1111;
        seen = 0;
        for (int k = 0; k < 100 && seen == 0; k++) begin
            @(negedge clk);
            #1;
            if (gnt1 != 4'h0) seen = 1;
        end
        chk("run_reached", seen, 32'd1);
        sv = 1'b1; seed = 32'h12345678;
        @(negedge clk);
        sv = 1'b0;
        #1;
        chk("seedwin_gnt1", {28'h0, gnt1}, 32'h0);
        chk("seedwin_ready1", {31'h0, rdy1}, 32'h0);

        // Randomized traffic.
        // Requesters hold req until they see their grant, then randomly keep
        // or drop it. Seeds are occasional single-cycle pulses, and one reset
        // lands partway through.
        prev_sv = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (i == 2000) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
            for (int b = 0; b < 4; b++) begin
                if (gnt0[b]) req0[b] = ($urandom_range(0, 1) == 1);
                else if (!req0[b]) req0[b] = ($urandom_range(0, 2) == 0);
                if (gnt1[b]) req1[b] = ($urandom_range(0, 1) == 1);
                else if (!req1[b]) req1[b] = ($urandom_range(0, 2) == 0);
            end
            sv = !prev_sv && ($urandom_range(0, 150) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            prev_sv = sv;
        end
        @(negedge clk);
        sv = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing the generator (range 2..16).
REQ-002 The block SHALL have parameter WARMUP, default 64, giving the number of LFSR steps discarded after each seed load (0 allowed).
REQ-003 The block SHALL have parameter DEFAULT_SEED, default 32'h00000001, giving the substitute seed and the reset LFSR contents.
REQ-004 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 seed_valid  input  1  single-cycle pulse that loads seed into the LFSR.
REQ-007 seed  input  32  seed value, sampled when seed_valid=1.
REQ-008 req  input  NUM_REQ  per-requester request level, held high until the matching gnt bit is seen.
REQ-009 gnt  output  NUM_REQ  one-hot grant, registered, high for exactly one cycle per grant.
REQ-010 rnd_data  output  32  random word delivered with the grant, valid only when rnd_valid=1.
REQ-011 rnd_valid  output  1  high in the same cycle as any gnt bit.
REQ-012 ready  output  1  high only in state RUN.

Function
REQ-013 The block SHALL hold a 32-bit LFSR that shifts left with new bit0 = NOT(b31 XOR b21 XOR b1 XOR b0).
REQ-014 The LFSR SHALL step only on a grant edge or on a WARMUP step edge; it SHALL hold in all other cycles.
REQ-015 The FSM SHALL have exactly three states: UNSEEDED, WARMUP and RUN.
REQ-016 From any state, seed_valid=1 SHALL load the LFSR at that edge, clear the warm-up counter, and enter WARMUP, or RUN when WARMUP=0.
REQ-017 A seed of 32'hFFFFFFFF (the XNOR lock-up state) SHALL be replaced by DEFAULT_SEED at load.
REQ-018 In WARMUP, the LFSR SHALL step once per cycle; after WARMUP steps, the state SHALL enter RUN on that same edge.
REQ-019 The warm-up counter SHALL be $clog2(WARMUP+1) bits wide and SHALL NOT wrap.
REQ-020 In UNSEEDED and WARMUP, no grant SHALL be issued; req bits SHALL remain pending, not dropped.
REQ-021 In RUN, when req is nonzero and seed_valid=0, the block SHALL select one requester per cycle by round-robin.
REQ-022 Round-robin search SHALL start at pointer ptr and scan upward modulo NUM_REQ; the first set req bit wins.
REQ-023 After granting index i, ptr SHALL become (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0; with no grant, ptr SHALL hold.
REQ-024 Latency SHALL be one cycle: req sampled at edge t gives gnt[i]=1, rnd_valid=1 and rnd_data = the pre-step LFSR value during cycle t+1; the LFSR steps at edge t.
REQ-025 If the granted requester still holds req in cycle t+1, it SHALL be eligible again, behind the others in round-robin order.
REQ-026 A requester holding req continuously SHALL be granted within NUM_REQ RUN cycles.
REQ-027 When seed_valid=1 in a cycle that would otherwise grant, the seed SHALL win: no grant that cycle, and ptr holds.
REQ-028 gnt, rnd_valid and rnd_data SHALL drop to 0 in any cycle without a grant.
REQ-029 Consecutive grants SHALL deliver consecutive LFSR states, so no word is delivered twice between seed loads.

Reset
REQ-030 Reset=1 SHALL immediately force: state=UNSEEDED, LFSR=DEFAULT_SEED, ptr=0, warm-up counter=0, gnt=0, rnd_valid=0, rnd_data=0, ready=0.
REQ-031 Reset asserted mid-WARMUP or mid-grant SHALL discard that operation; after release, the block SHALL wait in UNSEEDED for a new seed_valid.

Verification
REQ-032 WARMUP=0, seed_valid with seed=32'h1, then req=4'b0001 held -> ready=1; gnt=0001 every cycle; rnd_data = 0x00000001, 0x00000002, 0x00000004, 0x00000009, 0x00000012.
REQ-033 WARMUP=0, seed=32'h1, req=4'b1111 held -> gnt = 0001, 0010, 0100, 1000, 0001 with rnd_data 0x1, 0x2, 0x4, 0x9, 0x12.
REQ-034 seed=32'hFFFFFFFF -> LFSR loads 32'h00000001; first grant returns 0x00000001 (WARMUP=0).
REQ-035 WARMUP=64, seed pulse, req=0001 held -> no gnt for 64 cycles after load; ready rises on the 64th step edge; first gnt in the following cycle.
REQ-036 In RUN with req=1111, seed_valid coincident with a grant cycle -> no gnt in the next cycle, state=WARMUP, ptr unchanged.
REQ-037 Reset pulsed mid-grant -> gnt, rnd_valid and ready clear asynchronously; no grants until a new seed_valid.
